ch_eqlz_unit: RTL
=================

// Module: ch_eqlz_unit
// PURPOSE
//  Equalizer stage directly downstream of channel estimation. Captures the 12 per-subcarrier channel
//  estimates, delivered 2 per cycle (h1/h2) while valid_eqlz is high, into a local buffer. Then, for each
//  data symbol, reads 12 REs from the demapper and outputs y*conj(H) and |H|^2 for the downstream divider/LLR stage.
// PARAMETERS
//  WIDTH      16  signed I/Q width of estimates and received REs
//  SC_NUM     12  subcarriers per symbol (fixed NB-IoT PRB; H pairs = SC_NUM/2)
//  DATA_SYMS  10  data symbols equalized per captured estimate set
// PORTS
//  clk          in   1        clock, single domain
//  rst          in   1        asynchronous, active-high reset
//  valid_eqlz   in   1        H pair valid from channel estimation
//  h1_re,h1_im  in   WIDTH    estimate, even subcarrier 2k
//  h2_re,h2_im  in   WIDTH    estimate, odd subcarrier 2k+1
//  data_ready   in   1        demapper holds a full data symbol
//  data_re,im   in   WIDTH    RE at data_addr, valid 1 cycle after data_rd
//  data_rd      out  1        RE read strobe
//  data_addr    out  4        subcarrier index 0..11
//  eq_re,eq_im  out  2*WIDTH+1 y*conj(H), signed, full precision
//  pwr          out  2*WIDTH+1 |H|^2, unsigned
//  out_valid    out  1        eq/pwr valid this cycle
//  sym_done     out  1        1-cycle pulse with last out_valid of a symbol
//  set_done     out  1        1-cycle pulse with last out_valid of symbol DATA_SYMS-1
//  err_ovf      out  1        sticky: valid_eqlz seen while not accepting H
// BEHAVIOUR
//  Reset (async, any time): FSM->IDLE; ptr, sym_cnt, pipeline flushed; all outputs 0; h_buf contents don't-care.
//  FSM: IDLE, LOAD_H, WAIT_DATA, EQ, DRAIN.
//  IDLE: valid_eqlz=1 -> write pair to h_buf[0],h_buf[1], ptr=1, -> LOAD_H.
//  LOAD_H: each valid_eqlz=1 cycle writes h1->h_buf[2*ptr], h2->h_buf[2*ptr+1], ptr++. Gaps allowed
//   (state/pointer hold). Write of pair 5 -> WAIT_DATA, sym_cnt=0.
//  Writes only in IDLE/LOAD_H. valid_eqlz=1 in WAIT_DATA/EQ/DRAIN: ignored, err_ovf<=1 until reset.
//  WAIT_DATA: data_ready sampled only here; 1 -> EQ next cycle. data_ready ignored in all other states.
//  EQ: data_rd=1 for exactly SC_NUM consecutive cycles, data_addr=0..11. Last read -> DRAIN.
//  Pipeline: cycle t data_rd/addr n; t+1 data_* and h_buf[n] registered; t+2 products registered;
//   t+3 out_valid=1 with sums. out_valid latency = 3 cycles after data_rd; 12 back-to-back outputs.
//  Arithmetic (signed, no rounding/saturation; products 2W bits, sums 2W+1 bits):
//   eq_re = y_re*h_re + y_im*h_im;  eq_im = y_im*h_re - y_re*h_im;  pwr = h_re^2 + h_im^2.
//   Full-scale -2^(W-1) operands cannot overflow 2W+1.
//  DRAIN: wait for last out_valid (addr 11). sym_done with it; sym_cnt++.
//   If sym_cnt was DATA_SYMS-1: set_done pulses, -> IDLE, H set consumed. Otherwise -> WAIT_DATA.
//  Data held between outputs: eq/pwr hold last value when out_valid=0. data_addr returns to 0 outside EQ.
//  No back-pressure on outputs; consumer must accept 1 result/cycle.
// TESTING
//  1 Reset: assert rst mid-EQ (addr 5) -> same cycle all outputs 0, out_valid stays 0, FSM IDLE;
//    a following full H load + symbol works normally.
//  2 H load with gaps: valid_eqlz pattern 1,1,0,1,1,0,0,1,1 with h1=2k+1, h2=2k+2 -> buffer holds 1..12,
//    WAIT_DATA entered after 6th pair, err_ovf=0.
//  3 Latency: data_ready=1 in WAIT_DATA -> data_rd 12 cycles addr 0..11;
//    first out_valid 3 cycles after first data_rd; sym_done on 12th output.
//  4 Arithmetic: h=(3,-4), y=(5,2) -> eq=(7,26), pwr=25; h=y=(-32768,-32768) -> eq=(2^31,0), pwr=2^31.
//  5 Symbol count: DATA_SYMS=10 symbols with data_ready toggled between them -> 10 sym_done, set_done on 10th, FSM IDLE;
//    11th data_ready ignored (no data_rd).
//  6 Overflow: valid_eqlz=1 during EQ -> err_ovf=1 (sticky), h_buf and outputs unchanged.

Source files
------------

// File: rtl/ch_eqlz_unit.sv
// Equalizer stage: buffers one set of 12 channel estimates, then
// streams y*conj(H) and |H|^2 for DATA_SYMS symbols per set.
module ch_eqlz_unit #(
  parameter int WIDTH     = 16,
  parameter int SC_NUM    = 12,
  parameter int DATA_SYMS = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_eqlz,
  input  logic signed [WIDTH-1:0]   h1_re,
  input  logic signed [WIDTH-1:0]   h1_im,
  input  logic signed [WIDTH-1:0]   h2_re,
  input  logic signed [WIDTH-1:0]   h2_im,
  input  logic                      data_ready,
  input  logic signed [WIDTH-1:0]   data_re,
  input  logic signed [WIDTH-1:0]   data_im,
  output logic                      data_rd,
  output logic [3:0]                data_addr,
  output logic signed [2*WIDTH:0]   eq_re,
  output logic signed [2*WIDTH:0]   eq_im,
  output logic [2*WIDTH:0]          pwr,
  output logic                      out_valid,
  output logic                      sym_done,
  output logic                      set_done,
  output logic                      err_ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int OW = 2 * WIDTH + 1;
  localparam int CW = $clog2(DATA_SYMS + 1);
  localparam logic [3:0]    LAST_SC   = 4'(SC_NUM - 1);
  localparam logic [2:0]    LAST_PAIR = 3'(SC_NUM / 2 - 1);
  localparam logic [CW-1:0] LAST_SYM  = CW'(DATA_SYMS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_H, WAIT_DATA, EQ, DRAIN
  } state_t;

  state_t        state;
  logic [2:0]    ptr;
  logic [CW-1:0] sym_cnt;

  logic signed [WIDTH-1:0] hb_re [SC_NUM];
  logic signed [WIDTH-1:0] hb_im [SC_NUM];

  logic       h_wr;
  logic       h_acc;
  logic [3:0] h_idx;

  assign h_acc = (state == IDLE) || (state == LOAD_H);
  assign h_wr  = valid_eqlz && h_acc;
  assign h_idx = (state == IDLE) ? 4'd0 : {ptr, 1'b0};

  // Estimate storage needs no reset; it is always rewritten before use.
  always_ff @(posedge clk) begin
    if (h_wr) begin
      hb_re[h_idx]        <= h1_re;
      hb_im[h_idx]        <= h1_im;
      hb_re[h_idx + 4'd1] <= h2_re;
      hb_im[h_idx + 4'd1] <= h2_im;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sym_cnt   <= '0;
      data_rd   <= 1'b0;
      data_addr <= '0;
      err_ovf   <= 1'b0;
    end else begin
      if (valid_eqlz && !h_acc)
        err_ovf <= 1'b1;
      unique case (state)
        IDLE: begin
          if (valid_eqlz) begin
            ptr   <= 3'd1;
            state <= LOAD_H;
          end
        end
        LOAD_H: begin
          if (valid_eqlz) begin
            if (ptr == LAST_PAIR) begin
              ptr     <= '0;
              sym_cnt <= '0;
              state   <= WAIT_DATA;
            end else begin
              ptr <= ptr + 3'd1;
            end
          end
        end
        WAIT_DATA: begin
          if (data_ready) begin
            data_rd   <= 1'b1;
            data_addr <= '0;
            state     <= EQ;
          end
        end
        EQ: begin
          if (data_addr == LAST_SC) begin
            data_rd   <= 1'b0;
            data_addr <= '0;
            state     <= DRAIN;
          end else begin
            data_addr <= data_addr + 4'd1;
          end
        end
        DRAIN: begin
          if (sym_done) begin
            if (sym_cnt == LAST_SYM) begin
              sym_cnt <= '0;
              state   <= IDLE;
            end else begin
              sym_cnt <= sym_cnt + CW'(1);
              state   <= WAIT_DATA;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic                    v0, v1, v2;
  logic                    l0, l1, l2;
  logic [3:0]              a0;
  logic signed [WIDTH-1:0] y1_re, y1_im, g1_re, g1_im;
  logic signed [PW-1:0]    p_rr, p_ii, p_ir, p_ri, p_hr, p_hi;

  // Read issue -> operand capture -> products -> sums on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
      l0 <= 1'b0; l1 <= 1'b0; l2 <= 1'b0;
      a0 <= '0;
      y1_re <= '0; y1_im <= '0;
      g1_re <= '0; g1_im <= '0;
      p_rr <= '0; p_ii <= '0; p_ir <= '0;
      p_ri <= '0; p_hr <= '0; p_hi <= '0;
    end else begin
      v0 <= data_rd;
      l0 <= data_rd && (data_addr == LAST_SC);
      a0 <= data_addr;
      v1 <= v0;
      l1 <= l0;
      v2 <= v1;
      l2 <= l1;
      if (v0) begin
        y1_re <= data_re;
        y1_im <= data_im;
        g1_re <= hb_re[a0];
        g1_im <= hb_im[a0];
      end
      if (v1) begin
        p_rr <= PW'(y1_re) * PW'(g1_re);
        p_ii <= PW'(y1_im) * PW'(g1_im);
        p_ir <= PW'(y1_im) * PW'(g1_re);
        p_ri <= PW'(y1_re) * PW'(g1_im);
        p_hr <= PW'(g1_re) * PW'(g1_re);
        p_hi <= PW'(g1_im) * PW'(g1_im);
      end
    end
  end

  assign eq_re     = OW'(p_rr) + OW'(p_ii);
  assign eq_im     = OW'(p_ir) - OW'(p_ri);
  assign pwr       = OW'(p_hr) + OW'(p_hi);
  assign out_valid = v2;
  assign sym_done  = v2 && l2;
  assign set_done  = sym_done && (state == DRAIN) && (sym_cnt == LAST_SYM);

endmodule
